// File: rtl/sha_msg_ctrl.sv
// sha_msg_ctrl: assembles message bytes into blocks, applies SHA padding and hands blocks to the compression core
// Ports:
//   clk, rst (async, active-low)
//   in_data/in_valid/in_last/in_ready : byte stream in, in_last marks the final message byte
//   blk_data/blk_valid/blk_first/blk_last/blk_ready : block out, byte k at blk_data[8*k +: 8]
//   busy : message in progress
module sha_msg_ctrl #(
  parameter int NB = 64,
  parameter int LB = NB / 8,
  parameter int LW = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [7:0]      in_data,
  input  logic            in_valid,
  input  logic            in_last,
  output logic            in_ready,
  output logic [8*NB-1:0] blk_data,
  output logic            blk_valid,
  output logic            blk_first,
  output logic            blk_last,
  input  logic            blk_ready,
  output logic            busy
);
  localparam int CW = $clog2(NB);
  typedef enum logic [1:0] {FILL, PAD, ZERO, SEND} state_e;
  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d, ptr_q, ptr_d;
  logic [8*NB-1:0] buf_q, buf_d;
  logic [LW-1:0]   bitlen_q, bitlen_d;
  logic            first_q, first_d, fin_q, fin_d, padq_q, padq_d, zq_q, zq_d, busy_q, busy_d;
  logic [8*LB-1:0] len_f;
  logic            acc;
  assign in_ready  = rst & (state_q == FILL);
  assign acc       = in_valid & in_ready;
  assign blk_valid = state_q == SEND;
  assign blk_first = blk_valid & first_q;
  assign blk_last  = blk_valid & fin_q;
  assign blk_data  = buf_q;
  assign busy      = busy_q;
  // length field is wider than the counter for 128-byte blocks; upper bits stay zero
  assign len_f     = (8*LB)'(bitlen_q);
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ptr_d    = ptr_q;
    buf_d    = buf_q;
    bitlen_d = bitlen_q;
    first_d  = first_q;
    fin_d    = fin_q;
    padq_d   = padq_q;
    zq_d     = zq_q;
    busy_d   = busy_q;
    case (state_q)
      FILL: if (acc) begin
        buf_d[8*cnt_q +: 8] = in_data;
        bitlen_d = bitlen_q + LW'(8);
        busy_d   = 1'b1;
        cnt_d    = cnt_q + 1'b1;
        if (in_last) begin
          cnt_d   = '0;
          ptr_d   = cnt_q + 1'b1;
          fin_d   = 1'b0;
          padq_d  = cnt_q == CW'(NB-1);
          state_d = (cnt_q == CW'(NB-1)) ? SEND : PAD;
        end else if (cnt_q == CW'(NB-1)) begin
          cnt_d   = '0;
          fin_d   = 1'b0;
          padq_d  = 1'b0;
          state_d = SEND;
        end
      end
      PAD: begin
        for (int k = 0; k < NB; k++)
          buf_d[8*k +: 8] = (k == int'(ptr_q)) ? 8'h80 : (k > int'(ptr_q)) ? 8'h00 : buf_q[8*k +: 8];
        // length only fits when the 0x80 marker leaves the whole length field free
        if (int'(ptr_q) + 1 <= NB - LB) begin
          for (int j = 0; j < LB; j++) buf_d[8*(NB-LB+j) +: 8] = len_f[8*(LB-1-j) +: 8];
          fin_d = 1'b1;
        end else begin
          fin_d = 1'b0;
          zq_d  = 1'b1;
        end
        state_d = SEND;
      end
      ZERO: begin
        buf_d = '0;
        for (int j = 0; j < LB; j++) buf_d[8*(NB-LB+j) +: 8] = len_f[8*(LB-1-j) +: 8];
        fin_d   = 1'b1;
        state_d = SEND;
      end
      default: if (blk_ready) begin
        first_d = 1'b0;
        if (fin_q) begin
          bitlen_d = '0;
          first_d  = 1'b1;
          busy_d   = 1'b0;
          state_d  = FILL;
        end else if (padq_q) begin
          ptr_d   = '0;
          padq_d  = 1'b0;
          state_d = PAD;
        end else if (zq_q) begin
          zq_d    = 1'b0;
          state_d = ZERO;
        end else begin
          state_d = FILL;
        end
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= FILL;
      cnt_q    <= '0;
      ptr_q    <= '0;
      buf_q    <= '0;
      bitlen_q <= '0;
      first_q  <= 1'b1;
      fin_q    <= 1'b0;
      padq_q   <= 1'b0;
      zq_q     <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ptr_q    <= ptr_d;
      buf_q    <= buf_d;
      bitlen_q <= bitlen_d;
      first_q  <= first_d;
      fin_q    <= fin_d;
      padq_q   <= padq_d;
      zq_q     <= zq_d;
      busy_q   <= busy_d;
    end
  end
endmodule
